// File: rtl/mem_arbiter.sv
// mem_arbiter: lets the instruction-fetch requester (I-side) and the load/store
// requester (D-side) share one downstream memory port.
//
// Only one command is accepted at a time. It is registered, issued downstream,
// and the read response is steered back to whichever side owns the transaction.
// The D-side wins ties. A starvation counter forces an I grant after
// STARVE_LIMIT consecutive D grants that were made while I was waiting.
//
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   i_start/i_ready/i_addr        fetch request handshake and address
//   i_rdata/i_rdata_valid         fetch response
//   d_start/d_ready/d_write       data request handshake and direction
//   d_addr/d_wdata/d_wmask        data request address, store data, store mask
//   d_rdata/d_rdata_valid         load response
//   mem_cmd_*/mem_addr/mem_w*     downstream command
//   mem_rdata/mem_rdata_valid     downstream read response
//
// Optional build macro MEM_ARB_STATS_EN adds the saturating counters
// stat_i_grants, stat_d_grants and stat_conflicts.

module mem_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_start,
    output logic                  i_ready,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic [DATA_WIDTH-1:0] i_rdata,
    output logic                  i_rdata_valid,
    input  logic                  d_start,
    input  logic                  d_write,
    output logic                  d_ready,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    input  logic [DATA_WIDTH-1:0] d_wmask,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  d_rdata_valid,
    output logic                  mem_cmd_start,
    output logic                  mem_cmd_write,
    input  logic                  mem_cmd_ready,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [DATA_WIDTH-1:0] mem_wmask,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_rdata_valid
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [31:0]           stat_i_grants,
    output logic [31:0]           stat_d_grants,
    output logic [31:0]           stat_conflicts
`endif
);

    // The streak counter must be able to hold STARVE_LIMIT itself.
    localparam int STREAK_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RESP} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_I, OWN_D} owner_t;

    state_t                state_q, state_d;
    owner_t                owner_q, owner_d;
    logic [STREAK_W-1:0]   streak_q, streak_d;
    logic                  cmd_write_q, cmd_write_d;
    logic [ADDR_WIDTH-1:0] cmd_addr_q, cmd_addr_d;
    logic [DATA_WIDTH-1:0] cmd_wdata_q, cmd_wdata_d;
    logic [DATA_WIDTH-1:0] cmd_wmask_q, cmd_wmask_d;

    logic inst_prio;
    logic in_idle;
    logic i_accept;
    logic d_accept;
    logic resp_valid;

    always_comb begin
        // Fetch gets priority only once D has won STARVE_LIMIT times in a row
        // against a waiting fetch; a limit of 0 disables this entirely.
        inst_prio = (STARVE_LIMIT != 0) && (streak_q >= STREAK_MAX);
        in_idle   = (state_q == IDLE) && !reset;
        i_ready   = in_idle && !(d_start && !inst_prio);
        d_ready   = in_idle && !(i_start && inst_prio);
        i_accept  = i_start && i_ready;
        d_accept  = d_start && d_ready;

        state_d     = state_q;
        owner_d     = owner_q;
        streak_d    = streak_q;
        cmd_write_d = cmd_write_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_wdata_d = cmd_wdata_q;
        cmd_wmask_d = cmd_wmask_q;

        case (state_q)
            IDLE: begin
                // At most one of the two accepts can be true in a cycle.
                if (d_accept) begin
                    state_d     = ISSUE;
                    owner_d     = OWN_D;
                    cmd_write_d = d_write;
                    cmd_addr_d  = d_addr;
                    cmd_wdata_d = d_wdata;
                    cmd_wmask_d = d_wmask;
                    if (!i_start)
                        streak_d = '0;
                    else if (streak_q != STREAK_MAX)
                        streak_d = streak_q + 1'b1;
                end else if (i_accept) begin
                    state_d     = ISSUE;
                    owner_d     = OWN_I;
                    cmd_write_d = 1'b0;
                    cmd_addr_d  = i_addr;
                    cmd_wdata_d = '0;
                    cmd_wmask_d = '0;
                    streak_d    = '0;
                end
            end
            ISSUE: begin
                // Stores expect no response, so they release the port at once.
                if (mem_cmd_ready) begin
                    if (cmd_write_q) begin
                        state_d = IDLE;
                        owner_d = OWN_NONE;
                    end else begin
                        state_d = WAIT_RESP;
                    end
                end
            end
            WAIT_RESP: begin
                if (mem_rdata_valid) begin
                    state_d = IDLE;
                    owner_d = OWN_NONE;
                end
            end
            default: begin
                state_d = IDLE;
                owner_d = OWN_NONE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            owner_q     <= OWN_NONE;
            streak_q    <= '0;
            cmd_write_q <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_wdata_q <= '0;
            cmd_wmask_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            streak_q    <= streak_d;
            cmd_write_q <= cmd_write_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_wdata_q <= cmd_wdata_d;
            cmd_wmask_q <= cmd_wmask_d;
        end
    end

    // Outputs are gated with reset so that nothing is signalled during the
    // reset cycle, even though the state is only cleared at the next edge.
    assign mem_cmd_start = (state_q == ISSUE) && !reset;
    assign mem_cmd_write = cmd_write_q;
    assign mem_addr      = cmd_addr_q;
    assign mem_wdata     = cmd_wdata_q;
    assign mem_wmask     = cmd_wmask_q;

    // A response strobe outside WAIT_RESP belongs to no transaction and is dropped.
    assign resp_valid    = (state_q == WAIT_RESP) && mem_rdata_valid && !reset;
    assign i_rdata_valid = resp_valid && (owner_q == OWN_I);
    assign d_rdata_valid = resp_valid && (owner_q == OWN_D);
    assign i_rdata       = mem_rdata;
    assign d_rdata       = mem_rdata;

`ifdef MEM_ARB_STATS_EN
    logic [31:0] stat_i_grants_q, stat_i_grants_d;
    logic [31:0] stat_d_grants_q, stat_d_grants_d;
    logic [31:0] stat_conflicts_q, stat_conflicts_d;

    always_comb begin
        stat_i_grants_d  = stat_i_grants_q;
        stat_d_grants_d  = stat_d_grants_q;
        stat_conflicts_d = stat_conflicts_q;
        if (i_accept && (stat_i_grants_q != '1))
            stat_i_grants_d = stat_i_grants_q + 32'd1;
        if (d_accept && (stat_d_grants_q != '1))
            stat_d_grants_d = stat_d_grants_q + 32'd1;
        if ((i_accept || d_accept) && i_start && d_start && (stat_conflicts_q != '1))
            stat_conflicts_d = stat_conflicts_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stat_i_grants_q  <= '0;
            stat_d_grants_q  <= '0;
            stat_conflicts_q <= '0;
        end else begin
            stat_i_grants_q  <= stat_i_grants_d;
            stat_d_grants_q  <= stat_d_grants_d;
            stat_conflicts_q <= stat_conflicts_d;
        end
    end

    assign stat_i_grants  = stat_i_grants_q;
    assign stat_d_grants  = stat_d_grants_q;
    assign stat_conflicts = stat_conflicts_q;
`endif

endmodule
